// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner and instruction prefetch FIFO feeding decode.
// Optional push-event counter on fetch_count when FETCH_STAT_EN is defined.
module fetch_queue #(
  parameter int         DEPTH    = 2,
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  pc_adr,
  input  logic [15:0] instruction,
  input  logic        redirect,
  input  logic [9:0]  redirect_adr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
`ifdef FETCH_STAT_EN
  output logic [9:0]  out_pc,
  output logic [15:0] fetch_count
`else
  output logic [9:0]  out_pc
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [9:0]    pc;
  logic [25:0]   store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  assign pc_adr    = pc;
  assign out_valid = (count != '0);
  assign out_instr = store[rd_ptr][25:10];
  assign out_pc    = store[rd_ptr][9:0];

  // A full queue still accepts a word when the head leaves, giving 1 instr/cycle.
  assign pop  = out_valid & out_ready;
  assign push = !redirect & ((count < CW'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= redirect_adr;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 10'd1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage is deliberately left out of reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push)
      store[wr_ptr] <= {instruction, pc};
  end

`ifdef FETCH_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (push && fetch_count != 16'hFFFF)
      fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule
